// File: rtl/match_sequencer.sv
// match_sequencer
//
// Game-flow sequencer for a two-player pad game. Walks through
// IDLE -> SERVE -> PLAY -> POINT/OVER, keeps both scores, and produces
// the control strobes the ball/pad logic needs. All outputs are registered.
//
// Optional feature: define MATCH_PAUSE_EN to enable the PAUSED state,
// entered from PLAY and left back to PLAY on each rising edge of pause.
//
// Parameters
//   WIN_SCORE    points needed to win (1..15)
//   SERVE_FRAMES frame ticks spent in SERVE (1..255)
//   POINT_FRAMES frame ticks spent in POINT (1..255)
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   frame_tick   one-cycle pulse per video frame
//   start        level, any player key held
//   miss_left    one-cycle pulse, ball passed the left pad
//   miss_right   one-cycle pulse, ball passed the right pad
//   pause        level, pause key (only used with MATCH_PAUSE_EN)
//   logic_en     enables ball and pad motion
//   ball_serve   one-cycle pulse on every entry into SERVE
//   serve_dir    initial ball direction, 0 = left, 1 = right
//   score_left   left player score
//   score_right  right player score
//   state        IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4 PAUSED=5
//   game_over    high iff state is OVER
//   winner       0 = left won, 1 = right won (valid with game_over)
module match_sequencer #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       pause,
  output logic       logic_en,
  output logic       ball_serve,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [2:0] state,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    POINT  = 3'd3,
    OVER   = 3'd4,
    PAUSED = 3'd5
  } state_t;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

  // Score increment that sticks at WIN so a score can never wrap or overshoot.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    if (s >= WIN) return WIN;
    else          return s + 4'd1;
  endfunction

  state_t     state_q, state_nx;
  logic [7:0] frame_cnt, frame_cnt_nx;
  logic [3:0] score_left_nx, score_right_nx;
  logic [3:0] inc_l, inc_r;
  logic       serve_dir_nx, winner_nx;
  logic       start_q, start_rise;

  assign start_rise = start & ~start_q;
  assign inc_l      = sat_inc(score_left);
  assign inc_r      = sat_inc(score_right);
  assign state      = state_q;

`ifdef MATCH_PAUSE_EN
  logic pause_q, pause_rise;
  assign pause_rise = pause & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = pause;
`endif

  always_comb begin
    state_nx       = state_q;
    score_left_nx  = score_left;
    score_right_nx = score_right;
    serve_dir_nx   = serve_dir;
    winner_nx      = winner;
    case (state_q)
      IDLE: begin
        if (start_rise) state_nx = SERVE;
      end
      SERVE: begin
        if (frame_tick && frame_cnt == SERVE_LAST) state_nx = PLAY;
      end
      PLAY: begin
        if (miss_left && miss_right) begin
          // Simultaneous miss: nobody scores, re-serve immediately.
          state_nx = SERVE;
        end else if (miss_left) begin
          score_right_nx = inc_r;
          serve_dir_nx   = 1'b1;
          if (inc_r == WIN) begin
            state_nx  = OVER;
            winner_nx = 1'b1;
          end else begin
            state_nx = POINT;
          end
        end else if (miss_right) begin
          score_left_nx = inc_l;
          serve_dir_nx  = 1'b0;
          if (inc_l == WIN) begin
            state_nx  = OVER;
            winner_nx = 1'b0;
          end else begin
            state_nx = POINT;
          end
        end
`ifdef MATCH_PAUSE_EN
        else if (pause_rise) begin
          state_nx = PAUSED;
        end
`endif
      end
      POINT: begin
        if (frame_tick && frame_cnt == POINT_LAST) state_nx = SERVE;
      end
      OVER: begin
        if (start_rise) begin
          score_left_nx  = 4'd0;
          score_right_nx = 4'd0;
          state_nx       = SERVE;
        end
      end
`ifdef MATCH_PAUSE_EN
      PAUSED: begin
        if (pause_rise) state_nx = PLAY;
      end
`endif
      default: state_nx = IDLE;
    endcase

    // Counter restarts on any state change; it only advances while timing
    // SERVE or POINT.
    frame_cnt_nx = frame_cnt;
    if (state_nx != state_q)
      frame_cnt_nx = 8'd0;
    else if (frame_tick && (state_q == SERVE || state_q == POINT))
      frame_cnt_nx = frame_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt   <= 8'd0;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      logic_en    <= 1'b0;
      ball_serve  <= 1'b0;
      game_over   <= 1'b0;
      // Preset high so a key held through reset does not read as a press.
      start_q     <= 1'b1;
`ifdef MATCH_PAUSE_EN
      pause_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_nx;
      frame_cnt   <= frame_cnt_nx;
      score_left  <= score_left_nx;
      score_right <= score_right_nx;
      serve_dir   <= serve_dir_nx;
      winner      <= winner_nx;
      logic_en    <= (state_nx == PLAY);
      ball_serve  <= (state_nx == SERVE) && (state_q != SERVE);
      game_over   <= (state_nx == OVER);
      start_q     <= start;
`ifdef MATCH_PAUSE_EN
      pause_q     <= pause;
`endif
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Testbench for match_sequencer (WIN_SCORE=2, default frame counts).
// Stimulus pushes each expected output change into a queue just before the
// input that causes it; a monitor compares every observed output change
// against the queue head. An output change with nothing queued, or a queued
// change that never appears, is a failure.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, start, miss_left, miss_right, pause;
  logic       logic_en, ball_serve, serve_dir, game_over, winner;
  logic [3:0] score_left, score_right;
  logic [2:0] state;

  always #5 clk = ~clk;

  match_sequencer #(.WIN_SCORE(2), .SERVE_FRAMES(60), .POINT_FRAMES(90)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .miss_left(miss_left), .miss_right(miss_right), .pause(pause),
    .logic_en(logic_en), .ball_serve(ball_serve), .serve_dir(serve_dir),
    .score_left(score_left), .score_right(score_right), .state(state),
    .game_over(game_over), .winner(winner)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       dir;
    logic       len;
    logic       bs;
    logic       go;
    logic       win;
  } snap_t;

  typedef struct {
    string name;
    snap_t v;
  } exp_t;

  exp_t  q[$];
  snap_t e, prev, cur;
  int    checks = 0;
  int    passes = 0;
  logic  mon_en = 1'b0;

  function automatic snap_t take();
    snap_t s;
    s = '{st: state, sl: score_left, sr: score_right, dir: serve_dir,
          len: logic_en, bs: ball_serve, go: game_over, win: winner};
    return s;
  endfunction

  function automatic void compare(string name, snap_t got, snap_t req);
    checks++;
    if (got === req) passes++;
    else $display("FAIL %s: got st=%0d sl=%0d sr=%0d dir=%0b en=%0b bs=%0b go=%0b win=%0b, want st=%0d sl=%0d sr=%0d dir=%0b en=%0b bs=%0b go=%0b win=%0b",
                  name, got.st, got.sl, got.sr, got.dir, got.len, got.bs, got.go, got.win,
                  req.st, req.sl, req.sr, req.dir, req.len, req.bs, req.go, req.win);
  endfunction

  // Monitor: every change of the output tuple must match the queue head.
  always @(negedge clk) begin
    cur = take();
    if (mon_en && cur !== prev) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_change: got st=%0d sl=%0d sr=%0d bs=%0b en=%0b, want no change",
                 cur.st, cur.sl, cur.sr, cur.bs, cur.len);
      end else begin
        exp_t x;
        x = q.pop_front();
        compare(x.name, cur, x.v);
      end
    end
    prev = cur;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string name);
    q.push_back('{name, e});
  endtask

  // Entry into SERVE: one event with the pulse, one as it drops.
  task automatic push_serve(string name);
    e.st = 3'd1; e.len = 1'b0; e.go = 1'b0; e.bs = 1'b1;
    push({name, "_bs1"});
    e.bs = 1'b0;
    push({name, "_bs0"});
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc(); cyc(); cyc();
    end
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
    if (q.size() != 0) begin
      checks++;
      $display("FAIL %s_timeout: got %0d pending changes, want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic press_start(string name);
    start = 1'b0; cyc(); cyc();
    push_serve(name);
    start = 1'b1; cyc();
    drain(name);
  endtask

  task automatic serve_to_play(string name);
    ticks(59);
    e.st = 3'd2; e.len = 1'b1; e.bs = 1'b0;
    push(name);
    ticks(1);
    drain(name);
  endtask

  task automatic point_to_serve(string name);
    ticks(89);
    push_serve(name);
    ticks(1);
    drain(name);
  endtask

  task automatic pulse_miss(logic l, logic r);
    miss_left = l; miss_right = r; cyc();
    miss_left = 1'b0; miss_right = 1'b0; cyc();
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b1;
    miss_left = 1'b0; miss_right = 1'b0; pause = 1'b0;
    e = '0;
    cyc(); cyc(); cyc();
    @(negedge clk);
    compare("reset_values", take(), e);

    // Release reset with start still held: no press may be seen.
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
    repeat (8) cyc();

    press_start("start_to_serve");
    serve_to_play("serve_to_play");

    // Left miss: right scores, serve goes toward the right.
    e.st = 3'd3; e.sr = 4'd1; e.dir = 1'b1; e.len = 1'b0;
    push("miss_left_point");
    pulse_miss(1'b1, 1'b0);
    drain("miss_left_point");
    point_to_serve("point_to_serve");
    pulse_miss(1'b1, 1'b0);
    repeat (3) cyc();
    serve_to_play("serve_to_play2");

    // Both sides miss together: re-serve, nothing else changes.
    push_serve("double_miss");
    pulse_miss(1'b1, 1'b1);
    drain("double_miss");
    serve_to_play("serve_to_play3");

`ifdef MATCH_PAUSE_EN
    e.st = 3'd5; e.len = 1'b0;
    push("pause_enter");
    pause = 1'b1; cyc(); pause = 1'b0; cyc();
    drain("pause_enter");
    pulse_miss(1'b0, 1'b1);
    repeat (3) cyc();
    e.st = 3'd2; e.len = 1'b1;
    push("pause_leave");
    pause = 1'b1; cyc(); pause = 1'b0; cyc();
    drain("pause_leave");
`else
    pause = 1'b1; cyc(); pause = 1'b0;
    repeat (4) cyc();
`endif

    // Right miss: left scores, serve toward the left.
    e.st = 3'd3; e.sl = 4'd1; e.dir = 1'b0; e.len = 1'b0;
    push("miss_right_point");
    pulse_miss(1'b0, 1'b1);
    drain("miss_right_point");
    point_to_serve("point_to_serve2");
    serve_to_play("serve_to_play4");

    // Left reaches WIN_SCORE=2: straight to OVER, left wins.
    e.st = 3'd4; e.sl = 4'd2; e.len = 1'b0; e.go = 1'b1; e.win = 1'b0;
    push("left_wins");
    pulse_miss(1'b0, 1'b1);
    drain("left_wins");
    pulse_miss(1'b1, 1'b0);
    ticks(3);

    // New game from OVER clears the scores.
    e.sl = 4'd0; e.sr = 4'd0;
    press_start("restart_left");
    serve_to_play("serve_to_play5");

    // Right wins the second game.
    e.st = 3'd3; e.sr = 4'd1; e.dir = 1'b1; e.len = 1'b0;
    push("miss_left_point2");
    pulse_miss(1'b1, 1'b0);
    drain("miss_left_point2");
    point_to_serve("point_to_serve3");
    serve_to_play("serve_to_play6");
    e.st = 3'd4; e.sr = 4'd2; e.len = 1'b0; e.go = 1'b1; e.win = 1'b1;
    push("right_wins");
    pulse_miss(1'b1, 1'b0);
    drain("right_wins");

    e.sl = 4'd0; e.sr = 4'd0;
    press_start("restart_right");
    serve_to_play("serve_to_play7");

    // Reset in PLAY with start held: back to reset values, stays IDLE.
    e = '0;
    push("reset_in_play");
    rst_n = 1'b0; cyc();
    rst_n = 1'b1;
    drain("reset_in_play");
    ticks(2);
    repeat (4) cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
